mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Single-port memory arbiter between the instruction-fetch requester (fetch unit, read-only) and the data-cache requester (d_cache, read/write). It sits between those two clients and the shared `memory` block and keeps one transaction in flight at a time. Data requests have priority; a starvation counter guarantees fetch progress. A pipeline flush from the hazard unit cancels fetch traffic.

## Interface
- `ADDR_W`, 16, address width for both requesters and memory
- `DATA_W`, 16, data word width
- `STARVE_LIMIT`, 4, number of consecutive data grants made while fetch waits before fetch is forced to win; legal range 1..15

- `clk`  in  1  single clock, rising edge
- `n_rst`  in  1  asynchronous active-low reset
- `i_req`  in  1  fetch read request; held until `i_grant`
- `i_addr`  in  ADDR_W  fetch address
- `i_grant`  out  1  combinational one-cycle pulse: fetch request accepted this cycle
- `i_rvalid`  out  1  registered one-cycle pulse: `i_rdata` valid
- `i_rdata`  out  DATA_W  fetch read data; held between pulses
- `d_req`  in  1  data request; held until `d_grant`
- `d_we`  in  1  1 = write, 0 = read
- `d_addr`  in  ADDR_W  data address
- `d_wdata`  in  DATA_W  write data
- `d_grant`  out  1  combinational pulse: data request accepted
- `d_rvalid`  out  1  registered pulse: read data valid, or write complete
- `d_rdata`  out  DATA_W  data read data; updated only by reads
- `flush`  in  1  hazard-unit flush (mispredict); level, sampled every cycle
- `mem_req`  out  1  registered memory request, held until `mem_ack`
- `mem_we`  out  1  registered write enable
- `mem_addr`  out  ADDR_W  registered address
- `mem_wdata`  out  DATA_W  registered write data
- `mem_ack`  in  1  one-cycle completion pulse; `mem_rdata` valid with it
- `mem_rdata`  in  DATA_W  memory read data
- `busy`  out  1  1 when state is not IDLE

## Operation
- States: IDLE, BUSY_I, BUSY_D.
- Arbitration happens in IDLE only. Eligible fetch = `i_req & ~flush`.
  - Only one requester eligible: that requester wins.
  - Both eligible: data wins unless `starve_cnt == STARVE_LIMIT`, in which case fetch wins.
- On a grant:
  - Assert the matching grant pulse.
  - Latch addr, we (0 for fetch) and wdata into the `mem_*` registers; set `mem_req`.
  - Go to BUSY_I or BUSY_D.
- BUSY_x:
  - Hold `mem_*` stable.
  - On `mem_ack`: clear `mem_req`, capture `mem_rdata`, pulse the matching rvalid next cycle, return to IDLE.
  - `mem_ack` received in IDLE is ignored.
- `starve_cnt` (width 4):
  - Increments on each data grant made while `i_req & ~flush` is high; saturates at STARVE_LIMIT.
  - Clears on a fetch grant, or on any cycle with `i_req` low.
- Flush:
  - In IDLE: suppresses the fetch grant.
  - In BUSY_I: sets `drop`. The memory transaction still completes. On its `mem_ack`, `i_rvalid` stays 0 and `i_rdata` is unchanged.
  - In BUSY_D: no effect.
  - `drop` clears on return to IDLE. Flush coincident with `mem_ack` in BUSY_I also drops.
- Data writes: `d_rvalid` pulses on completion; `d_rdata` is unchanged.

## Timing
- Reset values (asynchronous, immediate):
  - State IDLE; `starve_cnt`, `drop` = 0.
  - All outputs 0: `mem_req`, `mem_we`, `mem_addr`, `mem_wdata`, `i_rvalid`, `i_rdata`, `d_rvalid`, `d_rdata`, `busy`.
  - The grants are 0 because `n_rst` low forces them low.
- Reset mid-transaction aborts the transaction and drops `mem_req` immediately; no rvalid is produced. `memory` shares `n_rst`.
- Cycle N: grant (IDLE).
- Cycle N+1 onward: `mem_req` = 1, `busy` = 1.
- Ack in cycle M ≥ N+1: rvalid in M+1, IDLE in M+1, next grant possible in M+1.
- Minimum period with a same-cycle ack is 2 cycles per transaction. The rvalid of one transaction coincides with the next grant.
- The requester may change addr/data or drop req the cycle after its grant.

## Test plan
- Single fetch: `i_req` with `i_addr`=0x0040; memory acks 2 cycles after `mem_req`, `mem_rdata`=0xBEEF → `i_grant` at N, `mem_req` N+1..N+2, `i_rvalid` with `i_rdata`=0xBEEF at N+3, `busy` low at N+3.
- Data write then read: write 0x1234 to 0x0100, then read 0x0100 with a memory model → `d_rvalid` after the write with `d_rdata` still 0; second `d_rvalid` with `d_rdata`=0x1234.
- Contention/starvation: `i_req` and `d_req` held high continuously, STARVE_LIMIT=4 → grant order D,D,D,D,I,D,D,D,D,I.
- Flush in flight: fetch granted, flush pulsed while in BUSY_I, ack returns 0xAAAA → no `i_rvalid`, `i_rdata` unchanged, state IDLE after ack; flush held in IDLE with both requests pending → only `d_grant`.
- Async reset mid-transaction: `n_rst` low during BUSY_D → `mem_req`, `busy` = 0 within the same cycle, no `d_rvalid`; after release, a new fetch completes normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: single-port memory arbiter between the instruction fetch unit
// (read-only) and the data cache (read/write). One transaction is in flight
// at a time. Data has priority, a starvation counter forces fetch through after
// STARVE_LIMIT data grants, and a pipeline flush cancels fetch traffic.
//
// Ports:
//   clk, n_rst                      clock, async active-low reset
//   i_req/i_addr -> i_grant         fetch request, combinational accept pulse
//   i_rvalid/i_rdata                registered fetch read return
//   d_req/d_we/d_addr/d_wdata       data request, d_grant combinational accept
//   d_rvalid/d_rdata                registered data completion / read return
//   flush                           hazard-unit flush (level)
//   mem_req/mem_we/mem_addr/mem_wdata  registered memory request, held to ack
//   mem_ack/mem_rdata               memory completion and read data
//   busy                            transaction in flight
module mem_arbiter #(
  parameter int unsigned ADDR_W       = 16,
  parameter int unsigned DATA_W       = 16,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_grant,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_grant,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  input  logic              flush,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] starve_q;
  logic [CNT_W-1:0] starve_d;
  logic             drop_q;
  logic             idle;
  logic             i_elig;
  logic             pick_i;
  logic             pick_d;

  // Arbitration: data wins unless fetch has been starved up to the limit.
  // Grants are gated by n_rst so they are low while reset is held.
  always_comb begin
    idle    = (state_q == IDLE);
    i_elig  = i_req & ~flush;
    pick_i  = i_elig & (~d_req | (starve_q == LIMIT));
    pick_d  = d_req & ~pick_i;
    i_grant = n_rst & idle & pick_i;
    d_grant = n_rst & idle & pick_d;
  end

  // Starvation counter: any cycle without a fetch request, or a fetch grant,
  // restarts the count; data grants taken over a waiting fetch advance it.
  always_comb begin
    starve_d = starve_q;
    if (!i_req || i_grant) begin
      starve_d = '0;
    end else if (d_grant && i_elig && (starve_q < LIMIT)) begin
      starve_d = starve_q + CNT_W'(1);
    end
  end

  // State, memory request registers and registered returns.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= IDLE;
      starve_q  <= '0;
      drop_q    <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      i_rvalid  <= 1'b0;
      i_rdata   <= '0;
      d_rvalid  <= 1'b0;
      d_rdata   <= '0;
      busy      <= 1'b0;
    end else begin
      i_rvalid <= 1'b0;
      d_rvalid <= 1'b0;
      starve_q <= starve_d;
      case (state_q)
        IDLE: begin
          drop_q <= 1'b0;
          if (i_grant || d_grant) begin
            mem_req   <= 1'b1;
            busy      <= 1'b1;
            mem_we    <= d_grant & d_we;
            mem_addr  <= d_grant ? d_addr : i_addr;
            mem_wdata <= d_grant ? d_wdata : '0;
            state_q   <= d_grant ? BUSY_D : BUSY_I;
          end
        end
        BUSY_I: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            busy    <= 1'b0;
            drop_q  <= 1'b0;
            state_q <= IDLE;
            // A flush seen during the fetch, or on its ack, discards the data.
            if (!(drop_q || flush)) begin
              i_rvalid <= 1'b1;
              i_rdata  <= mem_rdata;
            end
          end else if (flush) begin
            drop_q <= 1'b1;
          end
        end
        BUSY_D: begin
          if (mem_ack) begin
            mem_req  <= 1'b0;
            busy     <= 1'b0;
            state_q  <= IDLE;
            d_rvalid <= 1'b1;
            if (!mem_we) begin
              d_rdata <= mem_rdata;
            end
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a transaction-level reference model and
// a simple memory responder with programmable ack latency.
module tb_mem_arbiter;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        i_req, d_req, d_we, flush, mem_ack;
  logic [15:0] i_addr, d_addr, d_wdata, mem_rdata;
  logic        i_grant, i_rvalid, d_grant, d_rvalid, mem_req, mem_we, busy;
  logic [15:0] i_rdata, d_rdata, mem_addr, mem_wdata;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(16), .DATA_W(16), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .n_rst(n_rst),
    .i_req(i_req), .i_addr(i_addr), .i_grant(i_grant),
    .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_grant(d_grant), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .flush(flush),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- memory responder ----------------
  logic [15:0] mem_arr [logic [15:0]];
  int ack_lat  = 2;
  int wait_cnt = 0;

  function automatic logic [15:0] rd(input logic [15:0] a);
    if (mem_arr.exists(a)) return mem_arr[a];
    return a ^ 16'h5A5A;
  endfunction

  // Acks in the ack_lat-th cycle that mem_req is seen high.
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = 16'h0;
    forever begin
      @(posedge clk); #1;
      mem_ack = 1'b0;
      if (!n_rst || !mem_req) begin
        wait_cnt = 0;
      end else begin
        wait_cnt++;
        if (wait_cnt >= ack_lat) begin
          mem_ack  = 1'b1;
          wait_cnt = 0;
          if (mem_we) mem_arr[mem_addr] = mem_wdata;
          else        mem_rdata = rd(mem_addr);
        end
      end
    end
  end

  // ---------------- reference model + per-cycle compare ----------------
  typedef struct {
    bit          is_d;
    bit          we;
    logic [15:0] addr;
    logic [15:0] wdata;
    bit          dropped;
  } txn_t;

  txn_t        fl[$];
  int          starve;
  logic        e_iv, e_dv, l_we, eig, edg, ielig;
  logic [15:0] e_ird, e_drd, l_addr, l_wdata;

  initial begin
    txn_t t;
    starve = 0; e_iv = 0; e_dv = 0; e_ird = 0; e_drd = 0;
    l_we = 0; l_addr = 0; l_wdata = 0;
    forever begin
      @(negedge clk);
      if (!n_rst) begin
        chk1("rst_i_grant", i_grant, 1'b0);
        chk1("rst_d_grant", d_grant, 1'b0);
        chk1("rst_mem_req", mem_req, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_mem_we", mem_we, 1'b0);
        chk16("rst_mem_addr", mem_addr, 16'h0);
        chk16("rst_mem_wdata", mem_wdata, 16'h0);
        chk1("rst_i_rvalid", i_rvalid, 1'b0);
        chk1("rst_d_rvalid", d_rvalid, 1'b0);
        chk16("rst_i_rdata", i_rdata, 16'h0);
        chk16("rst_d_rdata", d_rdata, 16'h0);
        fl.delete();
        starve = 0; e_iv = 0; e_dv = 0; e_ird = 0; e_drd = 0;
        l_we = 0; l_addr = 0; l_wdata = 0;
      end else begin
        eig = 0; edg = 0;
        ielig = i_req && !flush;
        if (fl.size() == 0) begin
          if (ielig && (!d_req || starve == LIMIT)) eig = 1;
          else if (d_req)                          edg = 1;
        end
        chk1("m_i_grant", i_grant, eig);
        chk1("m_d_grant", d_grant, edg);
        chk1("m_mem_req", mem_req, fl.size() != 0);
        chk1("m_busy", busy, fl.size() != 0);
        chk1("m_mem_we", mem_we, l_we);
        chk16("m_mem_addr", mem_addr, l_addr);
        chk16("m_mem_wdata", mem_wdata, l_wdata);
        chk1("m_i_rvalid", i_rvalid, e_iv);
        chk1("m_d_rvalid", d_rvalid, e_dv);
        chk16("m_i_rdata", i_rdata, e_ird);
        chk16("m_d_rdata", d_rdata, e_drd);
        // advance the model to the next cycle
        e_iv = 0; e_dv = 0;
        if (fl.size() != 0) begin
          if (mem_ack) begin
            t = fl.pop_front();
            if (!t.is_d) begin
              if (!(t.dropped || flush)) begin
                e_iv  = 1;
                e_ird = mem_rdata;
              end
            end else begin
              e_dv = 1;
              if (!t.we) e_drd = mem_rdata;
            end
          end else if (!fl[0].is_d && flush) begin
            t = fl[0];
            t.dropped = 1;
            fl[0] = t;
          end
        end else if (eig || edg) begin
          t.is_d    = edg;
          t.we      = edg && d_we;
          t.addr    = edg ? d_addr : i_addr;
          t.wdata   = edg ? d_wdata : 16'h0;
          t.dropped = 0;
          fl.push_back(t);
          l_we = t.we; l_addr = t.addr; l_wdata = t.wdata;
        end
        if (!i_req || eig)                         starve = 0;
        else if (edg && ielig && starve < LIMIT)   starve++;
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wait_rv(input bit is_d, input string name);
    for (int k = 0; k < 30; k++) begin
      step();
      if (is_d ? d_rvalid : i_rvalid) return;
    end
    chk1(name, 1'b0, 1'b1);
  endtask

  initial begin
    string glog;
    n_rst = 1'b1;
    i_req = 0; d_req = 0; d_we = 0; flush = 0;
    i_addr = 0; d_addr = 0; d_wdata = 0;
    mem_arr[16'h0040] = 16'hBEEF;
    mem_arr[16'h0080] = 16'hAAAA;
    #2 n_rst = 1'b0;
    repeat (2) step();
    // grants forced low while reset is held, even with both requests up
    i_req = 1; d_req = 1;
    #1;
    chk1("rst_hold_i_grant", i_grant, 1'b0);
    chk1("rst_hold_d_grant", d_grant, 1'b0);
    i_req = 0; d_req = 0;
    step();
    n_rst = 1'b1;
    chk1("post_rst_busy", busy, 1'b0);
    step();

    // single fetch, ack in the second mem_req cycle
    ack_lat = 2;
    i_req = 1; i_addr = 16'h0040;
    #1 chk1("t1_i_grant", i_grant, 1'b1);
    chk1("t1_d_grant", d_grant, 1'b0);
    step(); i_req = 0; i_addr = 0;
    chk1("t1_mem_req_n1", mem_req, 1'b1);
    chk16("t1_mem_addr", mem_addr, 16'h0040);
    chk1("t1_busy_n1", busy, 1'b1);
    step();
    chk1("t1_mem_req_n2", mem_req, 1'b1);
    step();
    chk1("t1_i_rvalid_n3", i_rvalid, 1'b1);
    chk16("t1_i_rdata", i_rdata, 16'hBEEF);
    chk1("t1_busy_n3", busy, 1'b0);
    chk1("t1_mem_req_n3", mem_req, 1'b0);

    // data write then read back, same-cycle ack
    ack_lat = 1;
    step();
    d_req = 1; d_we = 1; d_addr = 16'h0100; d_wdata = 16'h1234;
    #1 chk1("t2_wr_grant", d_grant, 1'b1);
    step(); d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
    chk1("t2_mem_we", mem_we, 1'b1);
    chk16("t2_mem_wdata", mem_wdata, 16'h1234);
    wait_rv(1, "t2_wr_rvalid_timeout");
    chk16("t2_wr_rdata", d_rdata, 16'h0000);
    d_req = 1; d_we = 0; d_addr = 16'h0100;
    #1 chk1("t2_rd_grant_b2b", d_grant, 1'b1);
    step(); d_req = 0; d_addr = 0;
    wait_rv(1, "t2_rd_rvalid_timeout");
    chk16("t2_rd_rdata", d_rdata, 16'h1234);

    // contention: both requests held, fetch forced every LIMIT+1 grants
    step();
    i_req = 1; i_addr = 16'h0040; d_req = 1; d_we = 0; d_addr = 16'h0100;
    glog = "";
    for (int k = 0; k < 80 && glog.len() < 10; k++) begin
      #1;
      if (i_grant)      glog = {glog, "I"};
      else if (d_grant) glog = {glog, "D"};
      step();
    end
    i_req = 0; d_req = 0;
    checks++;
    if (glog != "DDDDIDDDDI") begin
      errors++;
      $display("FAIL t3_grant_order: got %s expected DDDDIDDDDI", glog);
    end
    repeat (3) step();

    // flush while a fetch is in flight
    ack_lat = 3;
    i_req = 1; i_addr = 16'h0080;
    #1 chk1("t4_i_grant", i_grant, 1'b1);
    step(); i_req = 0; flush = 1;
    step(); flush = 0;
    for (int k = 0; k < 5; k++) begin
      step();
      chk1("t4_no_i_rvalid", i_rvalid, 1'b0);
    end
    chk16("t4_i_rdata_kept", i_rdata, 16'hBEEF);
    chk1("t4_idle", busy, 1'b0);
    // flush held in IDLE with both requests pending
    flush = 1; i_req = 1; i_addr = 16'h0042; d_req = 1; d_we = 0; d_addr = 16'h0100;
    #1 chk1("t4_fl_d_grant", d_grant, 1'b1);
    chk1("t4_fl_i_grant", i_grant, 1'b0);
    step(); d_req = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      chk1("t4_fl_no_i_grant", i_grant, 1'b0);
    end
    flush = 0;
    #1 chk1("t4_unflush_i_grant", i_grant, 1'b1);
    step(); i_req = 0;
    wait_rv(0, "t4_i_rvalid_timeout");
    chk16("t4_i_rdata_new", i_rdata, 16'h5A18);
    // flush coincident with ack also drops
    ack_lat = 1;
    step();
    i_req = 1; i_addr = 16'h0040;
    #1 chk1("t4b_i_grant", i_grant, 1'b1);
    step(); i_req = 0; flush = 1;
    step(); flush = 0;
    chk1("t4b_no_i_rvalid", i_rvalid, 1'b0);
    chk16("t4b_i_rdata_kept", i_rdata, 16'h5A18);
    chk1("t4b_idle", busy, 1'b0);

    // async reset during a data transaction
    ack_lat = 4;
    step();
    d_req = 1; d_we = 0; d_addr = 16'h0100;
    #1 chk1("t5_d_grant", d_grant, 1'b1);
    step(); d_req = 0;
    step();
    chk1("t5_busy_before", busy, 1'b1);
    #2 n_rst = 1'b0;
    #1;
    chk1("t5_mem_req_async", mem_req, 1'b0);
    chk1("t5_busy_async", busy, 1'b0);
    step();
    chk1("t5_no_d_rvalid", d_rvalid, 1'b0);
    step(); n_rst = 1'b1;
    chk1("t5_no_d_rvalid2", d_rvalid, 1'b0);
    chk16("t5_d_rdata", d_rdata, 16'h0000);
    ack_lat = 2;
    step();
    i_req = 1; i_addr = 16'h0040;
    #1 chk1("t5_i_grant", i_grant, 1'b1);
    step(); i_req = 0;
    wait_rv(0, "t5_i_rvalid_timeout");
    chk16("t5_i_rdata", i_rdata, 16'hBEEF);

    repeat (3) step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
